// File: rtl/axi_irq_ctrl.sv
// AXI4-Lite interrupt controller: collects up to 16 level/edge sources and drives one CPU irq line.
// Optional macro IRQ_CTRL_PRIO_EN adds a 2-bit-per-source PRIORITY register at 0x14.
module axi_irq_ctrl #(
    parameter int AXI_ADDR_BW_p = 12,
    parameter int AXI_DATA_BW_p = 32,
    parameter int IRQ_NBR_p     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
    input  logic                     i_axi_awvalid,
    input  logic [AXI_DATA_BW_p-1:0] i_axi_wdata,
    input  logic                     i_axi_wvalid,
    input  logic [3:0]               i_axi_wstrb,
    input  logic                     i_axi_bready,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
    input  logic                     i_axi_arvalid,
    input  logic                     i_axi_rready,
    output logic                     o_axi_awready,
    output logic                     o_axi_wready,
    output logic [1:0]               o_axi_bresp,
    output logic                     o_axi_bvalid,
    output logic                     o_axi_arready,
    output logic [AXI_DATA_BW_p-1:0] o_axi_rdata,
    output logic [1:0]               o_axi_rresp,
    output logic                     o_axi_rvalid,
    input  logic [IRQ_NBR_p-1:0]     i_irq_src,
    output logic                     o_irq
);

    // state   | meaning
    // IDLE    | no request; watching for an eligible source
    // REQ     | o_irq high, claim_id latched, waiting for a CLAIM read
    // CLAIMED | software owns claim_id, waiting for a matching COMPLETE
    typedef enum logic [1:0] {IDLE, REQ, CLAIMED} state_t;

`ifdef IRQ_CTRL_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
    logic [2*IRQ_NBR_p-1:0] prio_q;
    logic [1:0]             best;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    state_t                 state_q, state_d;
    logic [4:0]             claim_q, claim_d;
    logic [IRQ_NBR_p-1:0]   enable_q, edge_q, pend_edge_q, src_q;
    logic [IRQ_NBR_p-1:0]   pending, eligible, clr_mask;
    logic [3:0]             win_idx;
    logic                   win_found;
    logic                   wr_rdy_q, claim_rd_q;
    logic                   aw_hs, ar_hs, r_hs, wr_full, wr_mapped, rd_mapped;
    logic                   claim_fire, complete_fire;
    logic [2:0]             wr_off, rd_off;
    logic [AXI_DATA_BW_p-1:0] rd_data;
    logic                   unused_bits;

    assign unused_bits = ^{i_axi_awaddr, i_axi_araddr, i_axi_wdata};

    assign o_axi_awready = wr_rdy_q;
    assign o_axi_wready  = wr_rdy_q;
    assign aw_hs   = wr_rdy_q & i_axi_awvalid & i_axi_wvalid;
    assign ar_hs   = o_axi_arready & i_axi_arvalid;
    assign r_hs    = o_axi_rvalid & i_axi_rready;
    assign wr_off  = i_axi_awaddr[4:2];
    assign rd_off  = i_axi_araddr[4:2];
    assign wr_full = &i_axi_wstrb;
    assign wr_mapped = (wr_off <= 3'd4) || (PRIO_EN && wr_off == 3'd5);
    assign rd_mapped = (rd_off <= 3'd4) || (PRIO_EN && rd_off == 3'd5);

    assign pending  = (edge_q & pend_edge_q) | (~edge_q & src_q);
    assign eligible = pending & enable_q;

    // The claim takes effect when the CLAIM data is actually accepted on R.
    assign claim_fire    = r_hs & claim_rd_q & (state_q == REQ);
    assign complete_fire = aw_hs & wr_full & (wr_off == 3'd4) & (state_q == CLAIMED)
                         & (i_axi_wdata[4:0] == claim_q);

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < IRQ_NBR_p; i++)
            clr_mask[i] = claim_fire && (claim_q == 5'(i + 1));
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef IRQ_CTRL_PRIO_EN
        best = 2'd0;
        for (int i = 0; i < IRQ_NBR_p; i++) begin
            if (eligible[i] && prio_q[2*i +: 2] > best) begin
                best    = prio_q[2*i +: 2];
                win_idx = 4'(i);
            end
        end
        win_found = (best != 2'd0);
`else
        for (int i = IRQ_NBR_p - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx   = 4'(i);
                win_found = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        rd_data = '0;
        case (rd_off)
            3'd0: rd_data = AXI_DATA_BW_p'(pending);
            3'd1: rd_data = AXI_DATA_BW_p'(enable_q);
            3'd2: rd_data = AXI_DATA_BW_p'(edge_q);
            3'd3: rd_data = (state_q == REQ) ? AXI_DATA_BW_p'(claim_q) : '0;
`ifdef IRQ_CTRL_PRIO_EN
            3'd5: rd_data = AXI_DATA_BW_p'(prio_q);
`endif
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        claim_d = claim_q;
        o_irq   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    claim_d = 5'(win_idx) + 5'd1;
                    state_d = REQ;
                end
            end
            REQ: begin
                o_irq = 1'b1;
                if (claim_fire)
                    state_d = CLAIMED;
                else if (!win_found)
                    state_d = IDLE;
            end
            CLAIMED: begin
                if (complete_fire)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            claim_q       <= '0;
            enable_q      <= '0;
            edge_q        <= '0;
            pend_edge_q   <= '0;
            src_q         <= '0;
            wr_rdy_q      <= 1'b0;
            o_axi_bvalid  <= 1'b0;
            o_axi_bresp   <= 2'b00;
            o_axi_arready <= 1'b0;
            o_axi_rvalid  <= 1'b0;
            o_axi_rdata   <= '0;
            o_axi_rresp   <= 2'b00;
            claim_rd_q    <= 1'b0;
`ifdef IRQ_CTRL_PRIO_EN
            prio_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            claim_q     <= claim_d;
            src_q       <= i_irq_src;
            // Set has priority over the claim clear.
            pend_edge_q <= (pend_edge_q & ~clr_mask) | (i_irq_src & ~src_q & edge_q);

            wr_rdy_q <= i_axi_awvalid & i_axi_wvalid & ~o_axi_bvalid & ~wr_rdy_q;
            if (aw_hs) begin
                o_axi_bvalid <= 1'b1;
                o_axi_bresp  <= wr_mapped ? 2'b00 : 2'b10;
                if (wr_full) begin
                    case (wr_off)
                        3'd1: enable_q <= i_axi_wdata[IRQ_NBR_p-1:0];
                        3'd2: edge_q   <= i_axi_wdata[IRQ_NBR_p-1:0];
`ifdef IRQ_CTRL_PRIO_EN
                        3'd5: prio_q   <= i_axi_wdata[2*IRQ_NBR_p-1:0];
`endif
                        default: ;
                    endcase
                end
            end else if (i_axi_bready) begin
                o_axi_bvalid <= 1'b0;
            end

            o_axi_arready <= i_axi_arvalid & ~o_axi_rvalid & ~o_axi_arready;
            if (ar_hs) begin
                o_axi_rvalid <= 1'b1;
                o_axi_rdata  <= rd_data;
                o_axi_rresp  <= rd_mapped ? 2'b00 : 2'b10;
                claim_rd_q   <= (rd_off == 3'd3) && (state_q == REQ);
            end else if (r_hs) begin
                o_axi_rvalid <= 1'b0;
                claim_rd_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_irq_ctrl.sv
// Self-checking bench for axi_irq_ctrl: directed scenarios plus randomized level/edge runs
// checked against a lowest-index / priority reference computed from source masks.
module tb_axi_irq_ctrl;

`ifdef IRQ_CTRL_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] awaddr = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [7:0]  src = '0;
    logic        o_axi_awready, o_axi_wready, o_axi_bvalid, o_axi_arready, o_axi_rvalid, o_irq;
    logic [1:0]  o_axi_bresp, o_axi_rresp;
    logic [31:0] o_axi_rdata;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_irq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .i_axi_wdata(wdata),
        .i_axi_wvalid(wvalid), .i_axi_wstrb(wstrb), .i_axi_bready(bready),
        .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .i_axi_rready(rready),
        .o_axi_awready(o_axi_awready), .o_axi_wready(o_axi_wready), .o_axi_bresp(o_axi_bresp),
        .o_axi_bvalid(o_axi_bvalid), .o_axi_arready(o_axi_arready), .o_axi_rdata(o_axi_rdata),
        .o_axi_rresp(o_axi_rresp), .o_axi_rvalid(o_axi_rvalid),
        .i_irq_src(src), .o_irq(o_irq)
    );

    function automatic int lowest_id(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i + 1;
        return 0;
    endfunction

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        n = 0;
        while (!o_axi_awready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!o_axi_bvalid && n < 50) begin @(negedge clk); n++; end
        if (!o_axi_bvalid) begin
            tests++; errors++;
            $display("FAIL wr_timeout addr=%h bvalid never seen", a);
        end
        resp = o_axi_bresp;
        bready = 1;
        @(negedge clk);
        bready = 0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1;
        n = 0;
        while (!o_axi_arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 0;
        n = 0;
        while (!o_axi_rvalid && n < 50) begin @(negedge clk); n++; end
        if (!o_axi_rvalid) begin
            tests++; errors++;
            $display("FAIL rd_timeout addr=%h rvalid never seen", a);
        end
        d = o_axi_rdata;
        resp = o_axi_rresp;
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (!o_irq && n < 40) begin @(negedge clk); n++; end
        tests++;
        if (o_irq !== 1'b1) begin
            errors++;
            $display("FAIL %s irq_rise got=%b want=1", tag, o_irq);
        end
    endtask

    task automatic pulse(input logic [7:0] p);
        @(negedge clk); src = p;
        @(negedge clk); src = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; logic [1:0] er;
        rst_n = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({o_irq, o_axi_awready, o_axi_wready, o_axi_bvalid, o_axi_arready, o_axi_rvalid,
             o_axi_bresp, o_axi_rresp, o_axi_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs irq=%b bv=%b rv=%b rdata=%h want all 0",
                     o_irq, o_axi_bvalid, o_axi_rvalid, o_axi_rdata);
        end
        rst_n = 1;
        for (int a = 0; a < 8; a++) begin
            axi_read(12'(a * 4), d, r);
            er = (a < 5 || (a == 5 && PRIO_EN)) ? 2'b00 : 2'b10;
            tests++;
            if (d !== 32'h0 || r !== er) begin
                errors++;
                $display("FAIL reset_read off=%0h got d=%h r=%b want d=0 r=%b", a * 4, d, r, er);
            end
        end
        axi_write(12'h018, 32'h1, 4'hF, r);
        tests++;
        if (r !== 2'b10) begin errors++; $display("FAIL unmapped_wr got=%b want=10", r); end
        tests++;
        if (o_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", o_irq); end
        axi_write(12'h014, 32'h5555, 4'hF, r);
    endtask

    task automatic test_edge();
        logic [31:0] d; logic [1:0] r;
        axi_write(12'h004, 32'h1, 4'hF, r);
        axi_write(12'h008, 32'h1, 4'hF, r);
        pulse(8'h01);
        wait_irq("edge");
        axi_read(12'h000, d, r);
        tests++;
        if (d !== 32'h1) begin errors++; $display("FAIL edge_pending got=%h want=1", d); end
        axi_read(12'h00C, d, r);
        tests++;
        if (d !== 32'h1) begin errors++; $display("FAIL edge_claim got=%h want=1", d); end
        tests++;
        if (o_irq !== 1'b0) begin errors++; $display("FAIL edge_irq_drop got=%b want=0", o_irq); end
        axi_read(12'h000, d, r);
        tests++;
        if (d !== 32'h0) begin errors++; $display("FAIL edge_pend_clr got=%h want=0", d); end
        axi_write(12'h010, 32'h1, 4'hF, r);
        tests++;
        if (r !== 2'b00) begin errors++; $display("FAIL edge_complete_resp got=%b want=00", r); end
        pulse(8'h01);
        wait_irq("edge_again");
        axi_read(12'h00C, d, r);
        tests++;
        if (d !== 32'h1) begin errors++; $display("FAIL edge_claim2 got=%h want=1", d); end
        axi_write(12'h010, 32'h1, 4'hF, r);
    endtask

    task automatic test_level();
        logic [31:0] d; logic [1:0] r;
        axi_write(12'h008, 32'h0, 4'hF, r);
        axi_write(12'h004, 32'h24, 4'hF, r);
        @(negedge clk); src = 8'h24;
        wait_irq("level1");
        axi_read(12'h00C, d, r);
        tests++;
        if (d !== 32'd3) begin errors++; $display("FAIL level_claim1 got=%0d want=3", d); end
        axi_write(12'h010, 32'd3, 4'hF, r);
        wait_irq("level2");
        axi_read(12'h00C, d, r);
        tests++;
        if (d !== 32'd3) begin errors++; $display("FAIL level_claim2 got=%0d want=3", d); end
        @(negedge clk); src = 8'h20;
        axi_write(12'h010, 32'd3, 4'hF, r);
        wait_irq("level3");
        axi_read(12'h00C, d, r);
        tests++;
        if (d !== 32'd6) begin errors++; $display("FAIL level_claim3 got=%0d want=6", d); end
        @(negedge clk); src = 8'h00;
        axi_write(12'h010, 32'd6, 4'hF, r);
        repeat (3) @(negedge clk);
        tests++;
        if (o_irq !== 1'b0) begin errors++; $display("FAIL level_quiet got=%b want=0", o_irq); end
    endtask

    task automatic test_mismatch();
        logic [31:0] d; logic [1:0] r;
        axi_write(12'h008, 32'h1, 4'hF, r);
        axi_write(12'h004, 32'h1, 4'hF, r);
        pulse(8'h01);
        wait_irq("mism");
        axi_read(12'h00C, d, r);
        tests++;
        if (d !== 32'd1) begin errors++; $display("FAIL mism_claim got=%0d want=1", d); end
        axi_write(12'h010, 32'd2, 4'hF, r);
        tests++;
        if (r !== 2'b00) begin errors++; $display("FAIL mism_resp got=%b want=00", r); end
        axi_write(12'h010, 32'd1, 4'b0111, r);
        tests++;
        if (r !== 2'b00) begin errors++; $display("FAIL strb_resp got=%b want=00", r); end
        pulse(8'h01);
        repeat (4) @(negedge clk);
        tests++;
        if (o_irq !== 1'b0) begin errors++; $display("FAIL mism_stays_claimed irq=%b want=0", o_irq); end
        axi_read(12'h00C, d, r);
        tests++;
        if (d !== 32'd0) begin errors++; $display("FAIL claim_outside_req got=%0d want=0", d); end
        axi_write(12'h010, 32'd1, 4'hF, r);
        wait_irq("mism_repend");
        axi_read(12'h00C, d, r);
        tests++;
        if (d !== 32'd1) begin errors++; $display("FAIL mism_claim2 got=%0d want=1", d); end
        axi_write(12'h010, 32'd1, 4'hF, r);
    endtask

    task automatic test_backpressure();
        logic [1:0] r; int n;
        axi_write(12'h004, 32'hA5, 4'hF, r);
        @(negedge clk);
        awaddr = 12'h004; wdata = 32'hA5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        n = 0;
        while (!o_axi_awready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (o_axi_bvalid !== 1'b1 || o_axi_awready !== 1'b0 || o_axi_bresp !== 2'b00) begin
                errors++;
                $display("FAIL b_stall c=%0d bvalid=%b awready=%b bresp=%b want 1 0 00",
                         c, o_axi_bvalid, o_axi_awready, o_axi_bresp);
            end
            @(negedge clk);
        end
        bready = 1;
        @(negedge clk);
        bready = 0; awvalid = 0; wvalid = 0;
        @(negedge clk);
        araddr = 12'h004; arvalid = 1;
        n = 0;
        while (!o_axi_arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (o_axi_rvalid !== 1'b1 || o_axi_arready !== 1'b0 || o_axi_rdata !== 32'hA5) begin
                errors++;
                $display("FAIL r_stall c=%0d rvalid=%b arready=%b rdata=%h want 1 0 a5",
                         c, o_axi_rvalid, o_axi_arready, o_axi_rdata);
            end
            @(negedge clk);
        end
        rready = 1;
        @(negedge clk);
        rready = 0; arvalid = 0;
        @(negedge clk);
        tests++;
        if (o_axi_bvalid !== 1'b0 || o_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL drained bvalid=%b rvalid=%b want 0 0", o_axi_bvalid, o_axi_rvalid);
        end
        axi_write(12'h004, 32'h0, 4'hF, r);
    endtask

    task automatic test_priority();
        logic [31:0] d; logic [1:0] r; int exp_id;
        axi_write(12'h004, 32'h0, 4'hF, r);
        axi_write(12'h008, 32'h0, 4'hF, r);
        axi_write(12'h014, 32'h31, 4'hF, r);
        tests++;
        if (r !== (PRIO_EN ? 2'b00 : 2'b10)) begin errors++; $display("FAIL prio_wr_resp got=%b", r); end
        axi_read(12'h014, d, r);
        tests++;
        if (d !== (PRIO_EN ? 32'h31 : 32'h0)) begin errors++; $display("FAIL prio_rd got=%h", d); end
        @(negedge clk); src = 8'h05;
        repeat (2) @(negedge clk);
        axi_write(12'h004, 32'h5, 4'hF, r);
        wait_irq("prio");
        exp_id = PRIO_EN ? 3 : 1;
        axi_read(12'h00C, d, r);
        tests++;
        if (d !== 32'(exp_id)) begin errors++; $display("FAIL prio_claim got=%0d want=%0d", d, exp_id); end
        axi_write(12'h010, 32'(exp_id), 4'hF, r);
        axi_write(12'h004, 32'h0, 4'hF, r);
        @(negedge clk); src = 8'h00;
        axi_write(12'h014, 32'h5555, 4'hF, r);
    endtask

    task automatic test_random_level();
        logic [31:0] d; logic [1:0] r; logic [7:0] en, elig; int exp_id;
        axi_write(12'h008, 32'h0, 4'hF, r);
        for (int it = 0; it < 20; it++) begin
            axi_write(12'h004, 32'h0, 4'hF, r);
            @(negedge clk); src = 8'($urandom);
            repeat (2) @(negedge clk);
            en = 8'($urandom);
            elig = en & src;
            exp_id = lowest_id(elig);
            axi_write(12'h004, 32'(en), 4'hF, r);
            if (elig == 8'h0) begin
                repeat (4) @(negedge clk);
                tests++;
                if (o_irq !== 1'b0) begin errors++; $display("FAIL rl_noirq it=%0d irq=%b", it, o_irq); end
            end else begin
                wait_irq("rand_level");
            end
            axi_read(12'h000, d, r);
            tests++;
            if (d !== 32'(src)) begin errors++; $display("FAIL rl_pend it=%0d got=%h want=%h", it, d, src); end
            axi_read(12'h00C, d, r);
            tests++;
            if (d !== 32'(exp_id)) begin
                errors++;
                $display("FAIL rl_claim it=%0d en=%h src=%h got=%0d want=%0d", it, en, src, d, exp_id);
            end
            if (exp_id != 0) axi_write(12'h010, 32'(exp_id), 4'hF, r);
        end
        axi_write(12'h004, 32'h0, 4'hF, r);
        @(negedge clk); src = 8'h00;
    endtask

    task automatic test_random_edge();
        logic [31:0] d; logic [1:0] r; logic [7:0] en, pend, mask; int exp_id;
        axi_write(12'h008, 32'hFF, 4'hF, r);
        for (int it = 0; it < 8; it++) begin
            axi_write(12'h004, 32'h0, 4'hF, r);
            en = 8'($urandom);
            pend = 8'($urandom);
            pulse(pend);
            for (int ph = 0; ph < 2; ph++) begin
                mask = (ph == 0) ? en : 8'hFF;
                axi_write(12'h004, 32'(mask), 4'hF, r);
                while ((pend & mask) != 8'h0) begin
                    exp_id = lowest_id(pend & mask);
                    wait_irq("rand_edge");
                    axi_read(12'h00C, d, r);
                    tests++;
                    if (d !== 32'(exp_id)) begin
                        errors++;
                        $display("FAIL re_claim it=%0d ph=%0d got=%0d want=%0d", it, ph, d, exp_id);
                    end
                    pend[exp_id - 1] = 1'b0;
                    axi_write(12'h010, 32'(exp_id), 4'hF, r);
                end
                repeat (3) @(negedge clk);
                axi_read(12'h000, d, r);
                tests++;
                if (d !== 32'(pend) || o_irq !== 1'b0) begin
                    errors++;
                    $display("FAIL re_pend it=%0d ph=%0d got=%h irq=%b want=%h irq=0", it, ph, d, o_irq, pend);
                end
            end
        end
        axi_write(12'h004, 32'h0, 4'hF, r);
    endtask

    initial begin
        test_reset();
        test_edge();
        test_level();
        test_mismatch();
        test_backpressure();
        test_priority();
        test_random_level();
        test_random_edge();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/axi_irq_ctrl.md
Name: axi_irq_ctrl

Overview:
- AXI4-Lite slave interrupt controller that collects up to 16 peripheral interrupt sources, for example the timer/counter done lines.
- Arbitrates among enabled pending sources and drives one level interrupt into one PicoRV32 irq bit.
- Software sequences service through a CLAIM read and a COMPLETE write.
- Sits behind the AXI-Lite crossbar as an additional slave port.

Parameters:
- AXI_ADDR_BW_p, 12, AXI address width; only bits [4:2] are decoded.
- AXI_DATA_BW_p, 32, AXI data width; fixed at 32.
- IRQ_NBR_p, 8, number of interrupt sources; legal range 1..16.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- i_axi_awaddr  input  AXI_ADDR_BW_p  write address
- i_axi_awvalid  input  1  write address valid
- i_axi_wdata  input  32  write data
- i_axi_wvalid  input  1  write data valid
- i_axi_wstrb  input  4  write strobes; any zero strobe makes the write a no-op that still returns OKAY
- i_axi_bready  input  1  write response ready
- i_axi_araddr  input  AXI_ADDR_BW_p  read address
- i_axi_arvalid  input  1  read address valid
- i_axi_rready  input  1  read data ready
- o_axi_awready  output  1  write address ready
- o_axi_wready  output  1  write data ready
- o_axi_bresp  output  2  write response
- o_axi_bvalid  output  1  write response valid
- o_axi_arready  output  1  read address ready
- o_axi_rdata  output  32  read data
- o_axi_rresp  output  2  read response
- o_axi_rvalid  output  1  read data valid
- i_irq_src  input  IRQ_NBR_p  interrupt sources; synchronous to clk
- o_irq  output  1  interrupt request to the CPU

Behaviour:
- Reset: all outputs 0. ENABLE, EDGE_SEL, PENDING and the source delay register are 0. FSM enters IDLE and claim_id is 0.
- Register map (byte offsets); bits above IRQ_NBR_p read 0:
  - 0x00 PENDING: RO.
  - 0x04 ENABLE: RW.
  - 0x08 EDGE_SEL: RW; 1 = rising-edge source, 0 = level source.
  - 0x0C CLAIM: RO; returns {27'b0, id[4:0]}, where id = index+1 and 0 = none.
  - 0x10 COMPLETE: WO; reads 0.
  - 0x14 PRIORITY: see Optional Feature.
- Unmapped offset: write has no effect; response is SLVERR (2'b10) on B or R. Read data is 0.
- Write channel:
  - o_axi_awready and o_axi_wready pulse together for 1 cycle when awvalid and wvalid are both high and no B is outstanding.
  - o_axi_bvalid rises the next cycle and holds until bready. bresp is OKAY (2'b00) for mapped offsets.
- Read channel:
  - o_axi_arready pulses for 1 cycle when arvalid is high and no R is outstanding.
  - o_axi_rvalid and o_axi_rdata follow the next cycle; rdata and rresp are held stable until rready.
- Edge sources:
  - src_q is i_irq_src delayed one cycle.
  - pend[i] is set on i_irq_src[i] & ~src_q[i].
  - pend[i] is cleared when CLAIM returns id i+1.
  - Set and clear in the same cycle: set wins.
- Level sources: pend[i] = src_q[i]. Claim does not clear it.
- Eligible = PENDING & ENABLE. Winner = lowest eligible index, re-evaluated every cycle while in IDLE.
- FSM:
  - IDLE: o_irq=0. If eligible != 0, latch claim_id = winner+1 and go to REQ.
  - REQ: o_irq=1. A CLAIM read returns claim_id and moves to CLAIMED at the R handshake cycle. o_irq drops the following cycle.
    - If eligible becomes 0 before the claim (source disabled or level dropped), return to IDLE with o_irq=0.
  - CLAIMED: o_irq=0. A COMPLETE write with wdata[4:0] == claim_id returns to IDLE the cycle after the AW/W handshake. A mismatched COMPLETE is ignored but still gets OKAY.
- A CLAIM read outside REQ returns 0 and has no side effect.
- Changing ENABLE or EDGE_SEL mid-service does not abort CLAIMED.
- Reset asserted mid-transaction drops bvalid and rvalid in the next cycle; no response is completed.

Optional Feature:
- Macro IRQ_CTRL_PRIO_EN.
- Defined:
  - PRIORITY at 0x14 is RW, with 2 bits per source; source i uses bits [2i+1:2i]; reset value 0.
  - Winner = highest priority among eligible sources; ties go to the lowest index.
  - Priority 0 sources are never selected.
- Undefined:
  - 0x14 is unmapped (SLVERR).
  - Fixed lowest-index priority; every enabled source is selectable.

Test Plan:
- Reset, then read all offsets → rdata 0, rresp OKAY; o_irq=0. Read 0x18 → SLVERR.
- ENABLE=0x01, EDGE_SEL=0x01, pulse i_irq_src[0] for 1 cycle:
  - → PENDING=0x01 and o_irq rises.
  - → CLAIM returns 1; o_irq low the next cycle; PENDING=0x00.
  - → COMPLETE=1 → IDLE.
- Level sources 2 and 5 high, ENABLE=0x24:
  - → CLAIM returns 3, then COMPLETE 3.
  - → o_irq re-asserts; CLAIM returns 3 again while src2 stays high.
  - → drop src2 → next claim returns 6.
- In CLAIMED with claim_id=1: write COMPLETE=2 → stays CLAIMED, bresp OKAY; COMPLETE=1 → IDLE.
- Hold bready and rready low for 5 cycles → bvalid, rvalid and rdata stay stable; no second awready or arready until drained.
- With IRQ_CTRL_PRIO_EN: PRIORITY=0x0000_0031 (src0=1, src2=3), sources 0 and 2 pending and enabled → CLAIM returns 3. Without the macro → CLAIM returns 1.
